// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package dmem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } dmem_state_t;

    localparam int DMEM_DEPTH     = 85;
    localparam int DMEM_MAX_BURST = 8;

    localparam logic CPU_PORT = 1'b0;
    localparam logic DMA_PORT = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: turns a request pair and a priority pointer
// into a one-hot grant. Reusable by any shared resource with two clients.
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_rr_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt = (i_rr_ptr == DMA_PORT) ? 2'b10 : 2'b01;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between the CPU (port 0) and DMA (port 1) for the single-port data
// memory: round-robin with locked bursts, registered response one cycle after grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH = DMEM_DEPTH,
    parameter int MAX_BURST = DMEM_MAX_BURST
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic        i_lock0,
    input  logic        i_lock1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    // state | meaning
    // IDLE  | no owner, round-robin picker decides
    // BURST | r_owner keeps the memory until it idles, unlocks or hits MAX_BURST
    localparam int CW = $clog2(MAX_BURST + 1);

    dmem_state_t   r_state;
    logic          r_owner;
    logic          r_rr_ptr;
    logic [CW-1:0] r_burst_cnt;
    logic [1:0]    r_rvalid;
    logic [1:0]    r_err;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_any;
    logic          w_sel;
    logic          w_we;
    logic          w_lock;
    logic          w_in_range;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rd_word;
    logic [CW-1:0] w_cnt_next;

    assign w_req = {i_req1, i_req0};

    dmem_rr_pick u_pick (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick)
    );

    always_comb begin
        w_gnt = 2'b00;
        if (!i_reset) begin
            if (r_state == ST_IDLE) begin
                w_gnt = w_pick;
            end else begin
                w_gnt[r_owner] = w_req[r_owner];
            end
        end
    end

    // With no grant the address path parks on the port that would win next.
    assign w_any      = |w_gnt;
    assign w_sel      = w_any ? w_gnt[1] : r_rr_ptr;
    assign w_addr     = w_sel ? i_addr1  : i_addr0;
    assign w_wdata    = w_sel ? i_wdata1 : i_wdata0;
    assign w_we       = w_sel ? i_we1    : i_we0;
    assign w_lock     = w_sel ? i_lock1  : i_lock0;
    assign w_in_range = (w_addr < 32'(MEM_DEPTH));
    assign w_rd_word  = (!w_we && w_in_range) ? i_mem_rd : 32'd0;
    assign w_cnt_next = r_burst_cnt + CW'(1);

    assign o_mem_a  = w_addr;
    assign o_mem_wd = w_wdata;
    assign o_mem_we = w_any & w_we & w_in_range;
    assign o_gnt0   = w_gnt[0];
    assign o_gnt1   = w_gnt[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= CPU_PORT;
            r_rr_ptr    <= CPU_PORT;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_rr_ptr <= ~w_sel;
                        if (w_lock && (MAX_BURST > 1)) begin
                            r_state     <= ST_BURST;
                            r_owner     <= w_sel;
                            r_burst_cnt <= CW'(1);
                        end
                    end
                end
                ST_BURST: begin
                    if (w_any && w_lock && (w_cnt_next < CW'(MAX_BURST))) begin
                        r_burst_cnt <= w_cnt_next;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_rr_ptr    <= ~r_owner;
                        r_burst_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & {2{~w_in_range}};
            if (w_gnt[0]) r_rdata0 <= w_rd_word;
            if (w_gnt[1]) r_rdata1 <= w_rd_word;
        end
    end

    assign o_rvalid0 = r_rvalid[0];
    assign o_rvalid1 = r_rvalid[1];
    assign o_err0    = r_err[0];
    assign o_err1    = r_err[1];
    assign o_rdata0  = r_rdata0;
    assign o_rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level model and a response scoreboard.
module tb_dmem_arbiter;

    localparam int DEPTH = 85;
    localparam int MAXB  = 8;

    typedef struct packed {
        int          tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        mem_init;

    int   total, bad, edges;
    int   own, favour, beats;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] hold0, hold1;
    logic [1:0]  last_gnt;

    dmem_arbiter dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_we0    (we0),
        .i_we1    (we1),
        .i_lock0  (lock0),
        .i_lock1  (lock1),
        .i_addr0  (addr0),
        .i_addr1  (addr1),
        .i_wdata0 (wdata0),
        .i_wdata1 (wdata1),
        .o_gnt0   (gnt0),
        .o_gnt1   (gnt1),
        .o_rvalid0(rvalid0),
        .o_rvalid1(rvalid1),
        .o_rdata0 (rdata0),
        .o_rdata1 (rdata1),
        .o_err0   (err0),
        .o_err1   (err1),
        .o_mem_a  (mem_a),
        .o_mem_wd (mem_wd),
        .o_mem_we (mem_we),
        .i_mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Word memory behind the arbiter: combinational read, write at the edge.
    assign mem_rd = (mem_a < 32'(DEPTH)) ? mem[mem_a[6:0]] : 32'hA5A5_A5A5;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
        end else if (mem_we && (mem_a < 32'(DEPTH))) begin
            mem[mem_a[6:0]] <= mem_wd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_port(input int p, input logic rv, input logic [31:0] rd, input logic er);
        exp_t e;
        logic have;
        if (p == 0) have = (q0.size() != 0) && (q0[0].tag <= edges);
        else        have = (q1.size() != 0) && (q1[0].tag <= edges);
        chk($sformatf("rvalid%0d", p), 32'(rv), 32'(have));
        if (have) begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            if (rv) begin
                chk($sformatf("rdata%0d", p), rd, e.rdata);
                chk($sformatf("err%0d", p), 32'(er), 32'(e.err));
                if (p == 0) hold0 = e.rdata; else hold1 = e.rdata;
            end
        end else begin
            chk($sformatf("rdata%0d_hold", p), rd, (p == 0) ? hold0 : hold1);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #1;
            edges++;
            if (reset) begin
                hold0 = 32'd0;
                hold1 = 32'd0;
            end
            check_port(0, rvalid0, rdata0, err0);
            check_port(1, rvalid1, rdata1, err1);
        end
    endtask

    // One bus cycle: drive the requests, predict the winner from the
    // arbitration rules, check the combinational side, queue the response.
    task automatic tick(input logic rst,
                        input logic r0, input logic w0, input logic l0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [31:0] a1, input logic [31:0] d1,
                        output int g);
        logic [1:0]  r, w, l;
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        in_r, ewe;
        exp_t        e;
        @(negedge clk);
        reset = rst;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #1;
        r = {r1, r0}; w = {w1, w0}; l = {l1, l0};
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        g = -1;
        if (rst) begin
            own = -1; favour = 0; beats = 0;
        end else if (own < 0) begin
            if (r == 2'b11)  g = favour;
            else if (r[0])   g = 0;
            else if (r[1])   g = 1;
            if (g >= 0) begin
                favour = 1 - g;
                if (l[g] && MAXB > 1) begin
                    own = g; beats = 1;
                end
            end
        end else if (r[own]) begin
            g = own;
            beats++;
            if (!l[own] || beats >= MAXB) begin
                favour = 1 - own; own = -1;
            end
        end else begin
            favour = 1 - own; own = -1;
        end
        last_gnt = {gnt1, gnt0};
        chk("gnt", 32'({gnt1, gnt0}), 32'({g == 1, g == 0}));
        ewe = 1'b0;
        if (g >= 0) begin
            in_r = a[g] < 32'(DEPTH);
            ewe  = w[g] && in_r;
            chk("mem_a", mem_a, a[g]);
            if (ewe) chk("mem_wd", mem_wd, d[g]);
            e.tag   = edges + 1;
            e.err   = !in_r;
            e.rdata = (!w[g] && in_r) ? ref_mem[a[g][6:0]] : 32'd0;
            if (ewe) ref_mem[a[g][6:0]] = d[g];
            if (g == 0) q0.push_back(e); else q1.push_back(e);
        end
        chk("mem_we", 32'(mem_we), 32'(ewe));
    endtask

    task automatic idle(input logic rst);
        int g;
        tick(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    initial begin
        int g, k, streak;
        logic r0, seen0;
        logic pv0, pw0, pl0, pv1, pw1, pl1, rst;
        logic [31:0] pa0, pd0, pa1, pd1;

        total = 0; bad = 0; edges = 0;
        own = -1; favour = 0; beats = 0;
        hold0 = 32'd0; hold1 = 32'd0;
        reset = 1'b1; mem_init = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        fork
            monitor();
        join_none

        idle(1'b1);
        mem_init = 1'b0;
        idle(1'b1);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);

        // Both request reads: CPU first, DMA next cycle.
        tick(0, 1, 0, 0, 3, 0, 1, 0, 0, 7, 0, g);
        chk("t1_first_gnt0", 32'(last_gnt), 32'b01);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0, g);
        chk("t1_second_gnt1", 32'(last_gnt), 32'b10);
        idle(1'b0);

        // Locked DMA burst with CPU waiting: forced release after MAX_BURST beats.
        tick(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, g);
        k = 10; streak = 0; seen0 = 1'b0; r0 = 1'b1;
        for (int c = 0; c < 30 && k < 20; c++) begin
            tick(0, r0, 0, 0, 2, 0, 1, 1, 1, 32'(k), 32'hB000_0000 + 32'(k), g);
            if (!seen0 && last_gnt[1]) streak++;
            if (last_gnt[0]) seen0 = 1'b1;
            if (g == 0) r0 = 1'b0;
            if (g == 1) k++;
        end
        chk("burst_len", 32'(streak), 32'd8);
        chk("burst_done", 32'(k), 32'd20);
        idle(1'b0);

        // Out-of-range write, then write/read-back of addr 5.
        tick(0, 1, 1, 0, 85, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, g);
        tick(0, 1, 1, 0, 5, 32'h1234_5678, 0, 0, 0, 0, 0, g);
        tick(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, g);
        idle(1'b0);

        // Reset on the third beat of a locked CPU burst.
        tick(0, 1, 0, 1, 20, 0, 0, 0, 0, 0, 0, g);
        tick(0, 1, 0, 1, 21, 0, 0, 0, 0, 0, 0, g);
        tick(1, 1, 0, 1, 22, 0, 1, 0, 0, 30, 0, g);
        chk("rst_mid_gnt", 32'(last_gnt), 32'b00);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0, 30, 0, g);
        chk("post_rst_rvalid", 32'({rvalid1, rvalid0}), 32'b00);
        chk("post_rst_gnt1", 32'(last_gnt), 32'b10);

        // Locked CPU drops its request after two beats while DMA waits.
        tick(0, 1, 0, 1, 40, 0, 1, 0, 0, 41, 0, g);
        tick(0, 1, 0, 1, 42, 0, 1, 0, 0, 41, 0, g);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0, 41, 0, g);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0, 41, 0, g);
        chk("drop_gnt1", 32'(last_gnt), 32'b10);
        tick(0, 1, 0, 0, 43, 0, 1, 0, 0, 44, 0, g);
        chk("rr_favours0", 32'(last_gnt), 32'b01);
        tick(0, 0, 0, 0, 0, 0, 1, 0, 0, 44, 0, g);
        idle(1'b0);

        // Random traffic; requests stay stable until granted.
        pv0 = 0; pv1 = 0; pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pv0 && $urandom_range(0, 2) == 0) begin
                pv0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
                pa0 = 32'($urandom_range(0, 95)); pd0 = $urandom;
            end
            if (!pv1 && $urandom_range(0, 3) != 0) begin
                pv1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
                pa1 = 32'($urandom_range(0, 95)); pd1 = $urandom;
            end
            pl0 = ($urandom_range(0, 3) == 0);
            pl1 = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick(rst, pv0, pw0, pl0, pa0, pd0, pv1, pw1, pl1, pa1, pd1, g);
            if (g == 0) pv0 = 1'b0;
            if (g == 1) pv1 = 1'b0;
        end

        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port, word-addressed data memory (combinational read, write on posedge clk).
- Port 0 is the CPU load/store path. Port 1 is the bootloader/debug DMA path.
- Arbitration is round-robin with optional locked bursts. A registered response (read data, valid, error) returns one cycle after each grant.
- Sits between the requesters and the data memory; drives the memory's A/WD/WE and consumes its RD.

Parameters:
- MEM_DEPTH, 85: number of valid words; addresses >= MEM_DEPTH are out of range.
- MAX_BURST, 8: maximum consecutive grants a locked owner may hold before forced release (>= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request, held until granted
- we0, we1  in  1 each  1 = write, 0 = read
- lock0, lock1  in  1 each  request to keep ownership after this grant
- addr0, addr1  in  32 each  word address
- wdata0, wdata1  in  32 each  write data
- gnt0, gnt1  out  1 each  access performed this cycle (combinational)
- rvalid0, rvalid1  out  1 each  response valid, one cycle after grant (reads and writes)
- rdata0, rdata1  out  32 each  registered read data
- err0, err1  out  1 each  with rvalid: address was out of range
- mem_a  out  32  to memory A
- mem_wd  out  32  to memory WD
- mem_we  out  1  to memory WE
- mem_rd  in  32  from memory RD

Behaviour:
- Reset:
  - Synchronous, active-high, on clk.
  - State=IDLE, rr_ptr=0, burst_cnt=0.
  - rvalid*/err*=0, rdata*=0.
  - gnt*=0 and mem_we=0 while reset is high.
- States:
  - IDLE: no owner.
  - BURST: owner register holds 0 or 1.
- IDLE:
  - Only one req: that port is granted.
  - Both req: the port equal to rr_ptr is granted.
  - After any grant, rr_ptr becomes the other port.
  - If the granted port has lock=1: go to BURST, owner=port, burst_cnt=1.
- BURST:
  - Only the owner can be granted; the other port stalls (gnt=0) regardless of its req.
  - Owner req=1: grant, burst_cnt++.
  - Exit to IDLE, taking effect next cycle, when any of these hold:
    - owner req=0 (no grant that cycle);
    - owner granted with lock=0;
    - owner granted and burst_cnt reaches MAX_BURST.
  - On exit, rr_ptr = the non-owner port.
  - MAX_BURST=1 behaves as no locking.
- Memory drive:
  - mem_a and mem_wd are muxed from the granted port. When nothing is granted, they come from port rr_ptr.
  - mem_we = grant & we & (addr < MEM_DEPTH) & !reset.
  - Out-of-range writes never reach memory.
- Response:
  - Cycle after grant: rvalid of the granted port = 1 for exactly one cycle.
  - rdata = mem_rd sampled at grant for in-range reads; 0 for writes or out-of-range accesses.
  - err = (addr >= MEM_DEPTH).
  - rdata holds its value until the next response on that port.
- Throughput: back-to-back grants are allowed every cycle, so one access per cycle in aggregate.
- Read-after-write to the same address in consecutive cycles returns the new data, because memory writes at the edge.
- Reset mid-burst: the burst is abandoned, state=IDLE, and no pending rvalid is issued.

Decomposition:
- Shared package dmem_pkg:
  - state encoding IDLE/BURST;
  - constants DMEM_DEPTH=85, DMEM_MAX_BURST=8;
  - port-index constants CPU_PORT=0, DMA_PORT=1.
- One sub-module is natural: dmem_rr_pick. It is the 2-way round-robin picker (req vector, rr_ptr -> one-hot grant). It is reusable by future shared resources.
- The burst FSM, muxing and response registers stay in dmem_arbiter.

Test Plan:
- Both req, reads at addr 3 (port 0) and addr 7 (port 1), no lock, after reset -> gnt0 in cycle 1 and gnt1 in cycle 2; rvalid0 in cycle 2 with rdata0=mem[3]; rvalid1 in cycle 3 with rdata1=mem[7].
- Port 1 locked writes to addr 10..19 with req0 continuously high, MAX_BURST=8 -> 8 consecutive gnt1 (mem[10..17] written), then gnt0, then port 1 resumes.
- Port 0 write addr 85 data 0xDEADBEEF -> mem_we=0; rvalid0=1 and err0=1 next cycle; mem[84] unchanged.
- Port 0 write addr 5 = 0x12345678, then read addr 5 the next cycle -> rdata0=0x12345678, err0=0.
- Reset asserted during the 3rd beat of a port-0 locked burst -> that cycle gnt*=0 and mem_we=0; next cycle rvalid*=0; state IDLE; a new req1 is granted on the first post-reset cycle.
- Port 0 lock=1, drops req after 2 beats while req1=1 -> gnt1 in the cycle after req0 drops; rr_ptr then favours port 0.
